// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_receiver #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 31250,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_TICKS  = CLOCK_HZ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW = $clog2(BIT_TICKS);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state_q, state_d;
  logic rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic push_q, push_d;
  logic ferr_d, perr_d, bad_par;
  logic bit_end, half_end;

`ifdef UART_RX_PARITY_EN
  logic pbit_q, pbit_d;
`endif

  assign bit_end  = cnt_q == CW'(BIT_TICKS - 1);
  assign half_end = cnt_q == CW'(HALF_TICKS - 1);

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      push_q        <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      push_q        <= push_d;
      framing_error <= ferr_d;
      parity_error  <= perr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q        <= pbit_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    bad_par = ^{shift_q, pbit_q};
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge detect on the synced line also blocks re-triggering on a break
        if (rx_prev && !rx_sync) state_d = START;
      end
      START: if (half_end) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_sync ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d   = '0;
        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) begin
        cnt_d   = '0;
        pbit_d  = rx_sync;
        state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        cnt_d   = '0;
        state_d = IDLE;
        ferr_d  = !rx_sync;
        perr_d  = bad_par;
        push_d  = rx_sync && !bad_par;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop, full, wr;

  assign data_valid = fifo_count != '0;
  assign full = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign pop  = data_valid && data_ready;
  assign wr   = push_q && (!full || pop);
  assign data_out = data_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock_50_000_000) begin
    if (wr) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop) fifo_count <= fifo_count + 1'b1;
      else if (!wr && pop) fifo_count <= fifo_count - 1'b1;
      if (push_q && !wr) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a frame-level model.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_receiver;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 31250;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rx, rdy;
  logic [DW-1:0] dout;
  logic dv, fe, pe, ovr;
  logic [$clog2(DEPTH):0] cnt;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLOCK_HZ(CLK_HZ), .BAUD_RATE(BAUD),
    .DATA_BITS(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock_50_000_000(clk),
    .reset(rst),
    .uart_rx(rx),
    .data_out(dout),
    .data_valid(dv),
    .data_ready(rdy),
    .framing_error(fe),
    .parity_error(pe),
    .overrun(ovr),
    .fifo_count(cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q[$];
  int pops = 0, vcyc = 0, fe_cnt = 0, pe_cnt = 0;
  bit exp_ovr = 1'b0;
  bit rnd_rdy = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dv) vcyc++;
      if (fe) fe_cnt++;
      if (pe) pe_cnt++;
      if (dv && rdy) begin
        pops++;
        check("pop_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          check("pop_data", 32'(dout), 32'(q[0]));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic hold(bit b, int n);
    repeat (n) begin
      tick();
      rx = b;
    end
  endtask

  // Model: a frame is good when the stop bit is high and (if enabled) parity is even
  task automatic send(logic [DW-1:0] d, bit stop, bit par);
    bit ok;
    ok = stop && (!PAR || (((^d) ^ par) == 1'b0));
    if (ok) begin
      if (q.size() < DEPTH) q.push_back(d);
      else exp_ovr = 1'b1;
    end
    hold(1'b0, BIT);
    for (int i = 0; i < DW; i++) hold(d[i], BIT);
    if (PAR) hold(par, BIT);
    hold(stop, BIT);
    hold(1'b1, 2 * BIT);
  endtask

  int p0, v0, f0, e0, exp_fe, exp_pe;
  logic [DW-1:0] rd;
  bit rs, rp, bad;

  initial begin
    rx = 1'b1;
    rdy = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(dv), 0);
    check("rst_count", 32'(cnt), 0);
    check("rst_overrun", 32'(ovr), 0);
    check("rst_ferr", 32'(fe), 0);
    check("rst_perr", 32'(pe), 0);
    check("rst_data", 32'(dout), 0);
    rst = 1'b0;
    repeat (5) tick();

    rdy = 1'b1;
    p0 = pops; v0 = vcyc;
    send(8'hA5, 1'b1, ^8'hA5);
    check("a5_pops", 32'(pops - p0), 1);
    check("a5_valid_cycles", 32'(vcyc - v0), 1);
    check("a5_count", 32'(cnt), 0);
    check("a5_q_empty", 32'(q.size()), 0);

    p0 = pops; f0 = fe_cnt; e0 = pe_cnt;
    hold(1'b0, HALF);
    hold(1'b1, 3 * BIT);
    check("glitch_count", 32'(cnt), 0);
    check("glitch_pops", 32'(pops - p0), 0);
    check("glitch_ferr", 32'(fe_cnt - f0), 0);
    check("glitch_perr", 32'(pe_cnt - e0), 0);
    send(8'h5A, 1'b1, ^8'h5A);
    check("post_glitch_pops", 32'(pops - p0), 1);

    p0 = pops; f0 = fe_cnt;
    send(8'h3C, 1'b0, ^8'h3C);
    check("frame_ferr", 32'(fe_cnt - f0), 1);
    check("frame_count", 32'(cnt), 0);
    check("frame_pops", 32'(pops - p0), 0);

    rdy = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) send(DW'(i), 1'b1, ^(DW'(i)));
    check("ovr_count", 32'(cnt), DEPTH);
    check("ovr_flag", 32'(ovr), 32'(exp_ovr));
    rdy = 1'b1;
    repeat (10) tick();
    check("ovr_drain_pops", 32'(pops - p0), DEPTH);
    check("ovr_drain_count", 32'(cnt), 0);
    check("ovr_sticky", 32'(ovr), 1);

    p0 = pops; e0 = pe_cnt;
    send(8'h07, 1'b1, 1'b0);
    check("par_bad_perr", 32'(pe_cnt - e0), 32'(PAR));
    check("par_bad_pops", 32'(pops - p0), 32'(!PAR));
    p0 = pops; e0 = pe_cnt;
    send(8'h07, 1'b1, 1'b1);
    check("par_good_perr", 32'(pe_cnt - e0), 0);
    check("par_good_pops", 32'(pops - p0), 1);

    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT);
    hold(1'b1, HALF);
    rst = 1'b1;
    exp_ovr = 1'b0;
    q.delete();
    repeat (3) tick();
    check("midrst_overrun", 32'(ovr), 0);
    check("midrst_count", 32'(cnt), 0);
    rst = 1'b0;
    hold(1'b1, 2 * BIT);
    check("midrst_idle_count", 32'(cnt), 0);
    p0 = pops; f0 = fe_cnt; e0 = pe_cnt;
    send(8'h12, 1'b1, ^8'h12);
    check("midrst_pops", 32'(pops - p0), 1);
    check("midrst_ferr", 32'(fe_cnt - f0), 0);
    check("midrst_perr", 32'(pe_cnt - e0), 0);

    rnd_rdy = 1'b1;
    f0 = fe_cnt; e0 = pe_cnt;
    exp_fe = 0; exp_pe = 0;
    for (int i = 0; i < 10; i++) begin
      rd = DW'($urandom);
      rs = $urandom_range(0, 7) != 0;
      bad = PAR && ($urandom_range(0, 4) == 0);
      rp = (^rd) ^ bad;
      if (!rs) exp_fe++;
      if (bad) exp_pe++;
      send(rd, rs, rp);
    end
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    repeat (20) tick();
    check("rnd_q_empty", 32'(q.size()), 0);
    check("rnd_count", 32'(cnt), 0);
    check("rnd_ferr", 32'(fe_cnt - f0), 32'(exp_fe));
    check("rnd_perr", 32'(pe_cnt - e0), 32'(exp_pe));
    check("rnd_overrun", 32'(ovr), 32'(exp_ovr));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 31250, serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-005 SHALL have port clock_50_000_000, input, 1, the single system clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port data_out, output, DATA_BITS, FIFO head word.
REQ-009 SHALL have port data_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port data_ready, input, 1, consumer accepts head word.
REQ-011 SHALL have port framing_error, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port parity_error, output, 1, one-cycle pulse on a parity mismatch (tied 0 without UART_RX_PARITY_EN).
REQ-013 SHALL have port overrun, output, 1, sticky flag set when a frame is dropped on a full FIFO.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchronizer; all logic SHALL use the synchronized value.
REQ-016 SHALL derive BIT_TICKS = CLOCK_HZ/BAUD_RATE (1600 at defaults) and HALF_TICKS = BIT_TICKS/2.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: SHALL go to START on a synchronized falling edge (1 -> 0), with the tick counter cleared.
REQ-019 START: SHALL sample at HALF_TICKS-1; if the line is low, go to DATA with the counter cleared; if high, treat it as a glitch and return to IDLE with no flags set.
REQ-020 DATA: SHALL sample every BIT_TICKS from the start-bit midpoint, LSB first, into bit index 0..DATA_BITS-1; after the last bit, go to PARITY if enabled, else to STOP.
REQ-021 STOP: SHALL sample one bit period after the last data/parity sample; a high sample is a valid frame and a low sample pulses framing_error for 1 cycle and discards the word.
REQ-022 After STOP the FSM SHALL return to IDLE and SHALL require the line to be high before accepting a new falling edge (break conditions produce no repeated frames).
REQ-023 A valid frame with no parity error SHALL be written to the FIFO in the cycle after the stop sample.
REQ-024 If the FIFO is full at write time, the word SHALL be dropped and overrun set; overrun SHALL clear only on reset.
REQ-025 FIFO: data_out SHALL present the head word whenever data_valid=1; a pop occurs when data_valid && data_ready.
REQ-026 On a simultaneous push and pop, fifo_count SHALL be unchanged; a push to a full FIFO with a pop in the same cycle SHALL succeed (no overrun).
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 data_ready while empty SHALL have no effect.
REQ-029 Latency from the stop-bit sample to data_valid=1 on an empty FIFO SHALL be 2 cycles.

Reset
REQ-030 While reset=1, the block SHALL hold: FSM = IDLE, counters = 0, FIFO empty, data_out = 0, data_valid = 0, framing_error = 0, parity_error = 0, overrun = 0, fifo_count = 0, synchronizer flops = 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no partial word written; the first frame after release requires a fresh falling edge.

Configuration
REQ-032 The macro UART_RX_PARITY_EN, when defined, SHALL add a PARITY state that samples one bit after the last data bit; even parity is checked over data plus parity bit.
REQ-033 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_error for 1 cycle and discard the word; the stop bit is still checked.
REQ-034 With UART_RX_PARITY_EN undefined, there SHALL be no PARITY state, the frame is start + DATA_BITS + stop, and parity_error is constant 0.

Verification
REQ-035 Bench SHALL cover: defaults, send 0xA5 with data_ready=1 -> data_out=0xA5 with data_valid high for 1 cycle, fifo_count back to 0.
REQ-036 Bench SHALL cover: 800-cycle low glitch on uart_rx -> no word, no error flags, FSM back in IDLE.
REQ-037 Bench SHALL cover: frame 0x3C with stop bit driven low -> framing_error pulses once, fifo_count stays 0.
REQ-038 Bench SHALL cover: data_ready=0, send 5 frames 0x01..0x05 -> fifo_count=4, overrun=1, then popping yields 0x01..0x04.
REQ-039 Bench SHALL cover: UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_error pulse, no word; with parity bit 1 -> data_out=0x07.
REQ-040 Bench SHALL cover: reset asserted at data bit 4 of 0xFF, then send 0x12 -> only 0x12 received, no flags.
